// File: rtl/ipif_pkg.sv
// Shared types and helpers for the IPIF command initiator.
package ipif_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} ipif_state_t;

  localparam int IPIF_DATA_W = 32;

  // Chip-enable count: one block of global words plus one block per link.
  function automatic int ipif_nce(input int nlinks, input int wpl);
    return (nlinks + 1) * wpl;
  endfunction

endpackage

// File: rtl/ipif_onehot_ce.sv
// Word index to one-hot chip-enable decode, with a legality flag for out-of-range indices.
module ipif_onehot_ce #(
  parameter int NCE   = 52,
  parameter int IDX_W = 7
) (
  input  logic [IDX_W-1:0] index,
  output logic [NCE-1:0]   onehot,
  output logic             index_legal
);

  always_comb begin
    index_legal = (32'(index) < 32'(NCE));
    onehot      = '0;
    if (index_legal) onehot = {{(NCE-1){1'b0}}, 1'b1} << index;
  end

endmodule

// File: rtl/ipif_cmd_initiator.sv
// Single-outstanding IPIF initiator: command port in, one-hot CE access with ack timeout,
// registered response port out.
module ipif_cmd_initiator
  import ipif_pkg::*;
#(
  parameter int NLINKS         = 12,
  parameter int WORD_PER_LINK  = 4,
  parameter int NCE            = ipif_nce(NLINKS, WORD_PER_LINK),
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDX_W         = $clog2(NCE) + 1
) (
  input  logic                   clk160,
  input  logic                   IPIF_bus2ip_resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [IDX_W-1:0]       cmd_index,
  input  logic [IPIF_DATA_W-1:0] cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IPIF_DATA_W-1:0] rsp_data,
  output logic                   rsp_write,
  output logic                   rsp_timeout,
  output logic                   rsp_error,
  output logic [15:0]            timeout_count,
  output logic [IPIF_DATA_W-1:0] IPIF_bus2ip_data,
  output logic [NCE-1:0]         IPIF_bus2ip_wrce,
  output logic [NCE-1:0]         IPIF_bus2ip_rdce,
  input  logic [IPIF_DATA_W-1:0] IPIF_ip2bus_data,
  input  logic                   IPIF_ip2bus_wrack,
  input  logic                   IPIF_ip2bus_rdack
);

  ipif_state_t state, state_next;

  logic [NCE-1:0]         ce_onehot;
  logic                   index_legal;
  logic                   cur_write, write_d;
  logic [15:0]            wait_cnt, wait_d;
  logic                   ack, timeout_hit, accept;
  logic                   ready_d, rsp_valid_d, rsp_write_d, rsp_timeout_d, rsp_error_d;
  logic [NCE-1:0]         wrce_d, rdce_d;
  logic [IPIF_DATA_W-1:0] data_d, rsp_data_d;
  logic [15:0]            tcount_d;

  ipif_onehot_ce #(.NCE(NCE), .IDX_W(IDX_W)) u_onehot (
    .index       (cmd_index),
    .onehot      (ce_onehot),
    .index_legal (index_legal)
  );

  // Only the ack matching the latched direction completes an access.
  assign ack         = cur_write ? IPIF_ip2bus_wrack : IPIF_ip2bus_rdack;
  assign timeout_hit = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign accept      = cmd_valid && cmd_ready;

  always_ff @(posedge clk160 or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) state <= IDLE;
    else                     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = index_legal ? ACCESS : RESP;
      ACCESS:  if (ack || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for every registered output; ack takes priority over timeout.
  always_comb begin
    ready_d       = 1'b0;
    wrce_d        = IPIF_bus2ip_wrce;
    rdce_d        = IPIF_bus2ip_rdce;
    data_d        = IPIF_bus2ip_data;
    rsp_valid_d   = rsp_valid;
    rsp_data_d    = rsp_data;
    rsp_write_d   = rsp_write;
    rsp_timeout_d = rsp_timeout;
    rsp_error_d   = rsp_error;
    tcount_d      = timeout_count;
    wait_d        = wait_cnt;
    write_d       = cur_write;
    case (state)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          write_d = cmd_write;
          wait_d  = '0;
          if (index_legal) begin
            wrce_d = cmd_write ? ce_onehot : '0;
            rdce_d = cmd_write ? '0 : ce_onehot;
            data_d = cmd_data;
          end else begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = '0;
            rsp_write_d   = cmd_write;
            rsp_timeout_d = 1'b0;
            rsp_error_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (ack || timeout_hit) begin
          wrce_d        = '0;
          rdce_d        = '0;
          data_d        = '0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = cur_write;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = !ack;
          rsp_data_d    = (ack && !cur_write) ? IPIF_ip2bus_data : '0;
          if (!ack && timeout_count != 16'hFFFF) tcount_d = timeout_count + 16'd1;
        end else begin
          wait_d = wait_cnt + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ready_d       = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_data_d    = '0;
          rsp_write_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_error_d   = 1'b0;
        end
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk160 or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      cmd_ready        <= 1'b0;
      IPIF_bus2ip_wrce <= '0;
      IPIF_bus2ip_rdce <= '0;
      IPIF_bus2ip_data <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_write        <= 1'b0;
      rsp_timeout      <= 1'b0;
      rsp_error        <= 1'b0;
      timeout_count    <= '0;
      wait_cnt         <= '0;
      cur_write        <= 1'b0;
    end else begin
      cmd_ready        <= ready_d;
      IPIF_bus2ip_wrce <= wrce_d;
      IPIF_bus2ip_rdce <= rdce_d;
      IPIF_bus2ip_data <= data_d;
      rsp_valid        <= rsp_valid_d;
      rsp_data         <= rsp_data_d;
      rsp_write        <= rsp_write_d;
      rsp_timeout      <= rsp_timeout_d;
      rsp_error        <= rsp_error_d;
      timeout_count    <= tcount_d;
      wait_cnt         <= wait_d;
      cur_write        <= write_d;
    end
  end

endmodule

// File: doc/ipif_cmd_initiator.md
# ipif_cmd_initiator

Single-outstanding IPIF bus initiator. It accepts register read and write commands on a valid/ready command port and drives the one-hot `IPIF_bus2ip_wrce`/`IPIF_bus2ip_rdce` chip-enables and `IPIF_bus2ip_data` into an IPIF register decoder, such as the per-link delay parameter decoder. It waits for `ip2bus_wrack`/`rdack` with a timeout and returns read data and status on a valid/ready response port. On-chip sequencers (delay scans, link bring-up) use it to reach IPIF register banks without going through AXI.

## Interface
- `NLINKS`, 12, number of links in the target register map.
- `WORD_PER_LINK`, 4, register words per link.
- `NCE`, `(NLINKS+1)*WORD_PER_LINK`, chip-enable width. Index 0..`WORD_PER_LINK-1` are global words.
- `TIMEOUT_CYCLES`, 16, ACCESS cycles without ack before abort. Range 2..65535.
- `clk160`  in  1  clock, shared with the IPIF decoder.
- `IPIF_bus2ip_resetn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_index`  in  `$clog2(NCE)+1`  register word index. The extra bit allows illegal-index detection.
- `cmd_data`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  32  read data. 0 for writes, errors and timeouts.
- `rsp_write`  out  1  echo of `cmd_write`.
- `rsp_timeout`  out  1  no ack within `TIMEOUT_CYCLES`.
- `rsp_error`  out  1  `cmd_index >= NCE`; no bus access was made.
- `timeout_count`  out  16  saturating count of timeouts since reset.
- `IPIF_bus2ip_data`  out  32  write data to the decoder.
- `IPIF_bus2ip_wrce`  out  NCE  one-hot write enable.
- `IPIF_bus2ip_rdce`  out  NCE  one-hot read enable.
- `IPIF_ip2bus_data`  in  32  read data from the decoder.
- `IPIF_ip2bus_wrack`  in  1  write acknowledge.
- `IPIF_ip2bus_rdack`  in  1  read acknowledge.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On handshake with a legal index: latch the command, drive the CE bit `1<<cmd_index` (wrce or rdce) and `bus2ip_data`=`cmd_data`, then go to ACCESS.
  - On handshake with an illegal index: no CE; go to RESP with `rsp_error`=1.
- ACCESS:
  - CE and data are held constant.
  - The wait counter increments each cycle.
  - Only the ack matching the direction counts (wrack for writes, rdack for reads).
  - On ack: capture `ip2bus_data` for reads, clear CE, go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES` with no ack: clear CE, set `rsp_timeout`, increment `timeout_count` (saturates at 0xFFFF), go to RESP.
  - Ack and timeout on the same edge: ack wins.
- RESP:
  - `rsp_valid`=1; all `rsp_*` fields are stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - Acks are ignored, which discards the stale extra-cycle ack from registered-ack decoders.
- CE outputs are never multi-hot. wrce and rdce are never high together.
- `bus2ip_data` returns to 0 when CE clears.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd_ready`=0 while reset is asserted, 1 on the first cycle after release.
  - All other outputs 0, including `timeout_count`; state = IDLE.
- Reset asserted mid-operation: CE and `rsp_valid` drop asynchronously. The pending command is discarded and produces no response.
- Against a decoder that acks one cycle after CE:
  - Acceptance at edge e0 raises CE after e0.
  - The ack is sampled at e2.
  - CE is high for exactly 2 cycles; `rsp_valid` rises after e2.
- Illegal index: `rsp_valid` rises the cycle after acceptance.
- Timeout: CE is high for exactly `TIMEOUT_CYCLES` cycles.
- Between consecutive accesses CE stays low for at least 2 cycles: RESP plus IDLE acceptance.
- Throughput: one command per 3 cycles at best.

## Structure
- `ipif_pkg` holds:
  - `ipif_state_t` enum (IDLE, ACCESS, RESP).
  - `IPIF_DATA_W=32`.
  - Function `ipif_nce(nlinks, wpl)`.
- Sub-module `ipif_onehot_ce`: index → NCE-wide one-hot plus an `index_legal` flag. Combinational, registered in the parent.

## Test plan
Bench uses a paired delay-parameter decoder with `NLINKS`=12, `WORD_PER_LINK`=4, `NCE`=52.
- Write index 5 (link 0 word 1) with data 0x0000_0103.
  - Required: `wrce`=1<<5 for exactly 2 cycles, no rdce activity.
  - Required: `rsp_valid` 2 cycles after acceptance with `rsp_write`=1, `rsp_timeout`=0, `rsp_error`=0.
- Read index 5 after that write → `rsp_data`=0x0000_0103.
- Read index 0 directly after reset → `rsp_data`=0x0000_0001 (global rstb default).
- Non-acking stub, `TIMEOUT_CYCLES`=16, read index 7.
  - Required: `rdce` high exactly 16 cycles, `rsp_timeout`=1, `rsp_data`=0, `timeout_count`=1.
- `cmd_index`=52.
  - Required: no CE ever asserted, `rsp_error`=1 one cycle after acceptance.
- `rsp_ready` held low 10 cycles:
  - Required: response fields stable throughout and `cmd_ready`=0.
- Reset asserted during ACCESS:
  - Required: CE=0 immediately, `rsp_valid` never asserted, `cmd_ready`=1 the first cycle after release.
